// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order pipeline.
// Resolves load-use stalls, taken-branch flushes and data-memory wait
// states. A memory access that stays unacknowledged too long parks the
// block in a sticky ERROR state until reset. Stall and flush statistics
// are kept in saturating counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memtoreg,
  input  logic             ex_regwr,
  input  logic             redirect,
  input  logic             mem_access,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             mem_req,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic hold;
  logic flush_apply;

  // Load-use hazard: the load in EX targets a register the ID instruction reads.
  always_comb begin
    lu = ex_memtoreg & ex_regwr & (ex_rt != 5'd0) &
         ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

  // Memory hold: an access is pending and not completing this cycle.
  always_comb begin
    hold = mem_access & ~mem_ack & (state_q != ERROR);
  end

  // State register and wait counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state: an ack always wins over a coincident timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_access & ~mem_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack | ~mem_access) begin
          state_d = RUN;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Pipeline control outputs, priority ERROR > hold > redirect > lu > normal.
  // A held redirect/lu is not flushed during the hold so it is re-evaluated
  // once the stages can advance again.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    mem_req      = mem_access;
    err          = 1'b0;
    flush_apply  = 1'b0;
    if (RESET) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_en      = 1'b0;
      idex_flush   = 1'b1;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      mem_req      = 1'b0;
    end else if (state_q == ERROR) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      mem_req      = 1'b0;
      err          = 1'b1;
    end else if (hold) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (redirect) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      flush_apply  = 1'b1;
    end else if (lu) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_flush   = 1'b1;
    end
  end

  // Saturating statistics counters, next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (~pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_apply && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Statistics counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. A driver applies directed and
// random per-cycle inputs, computes the expected response from the hazard
// rules and queues it; a monitor pops and compares every cycle. A second
// instance with 3-bit counters exercises counter saturation.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TMO   = 8;
  localparam int unsigned W_BIG = 16;
  localparam int unsigned W_SAT = 3;

  typedef struct {
    logic [4:0] rs, rt, exrt;
    logic       uses, mtr, rw, redir, acc, ack;
  } in_t;

  typedef struct {
    logic        pc, ifid, ifid_fl, idex, idex_fl, exmem, bubble, req, err;
    logic        idex_care;
    logic [1:0]  st;
    int unsigned stall, flush;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_uses_rt = 1'b0, ex_memtoreg = 1'b0, ex_regwr = 1'b0;
  logic redirect = 1'b0, mem_access = 1'b0, mem_ack = 1'b0;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
  logic memwb_bubble, mem_req, err;
  logic [1:0] state;
  logic [W_BIG-1:0] stall_cnt, flush_cnt;

  logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en;
  logic s_memwb_bubble, s_mem_req, s_err;
  logic [1:0] s_state;
  logic [W_SAT-1:0] s_stall_cnt, s_flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(W_BIG)) u_dut (
    .CLK(CLK), .RESET(RESET), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_memtoreg(ex_memtoreg),
    .ex_regwr(ex_regwr), .redirect(redirect), .mem_access(mem_access),
    .mem_ack(mem_ack), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_bubble(memwb_bubble), .mem_req(mem_req),
    .state(state), .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(W_SAT)) u_sat (
    .CLK(CLK), .RESET(RESET), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_memtoreg(ex_memtoreg),
    .ex_regwr(ex_regwr), .redirect(redirect), .mem_access(mem_access),
    .mem_ack(mem_ack), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
    .ifid_flush(s_ifid_flush), .idex_en(s_idex_en), .idex_flush(s_idex_flush),
    .exmem_en(s_exmem_en), .memwb_bubble(s_memwb_bubble), .mem_req(s_mem_req),
    .state(s_state), .err(s_err), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 CLK = ~CLK;

  exp_t        q[$];
  in_t         s;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: pipeline mode as plain flags and cycle counts.
  bit          m_err = 0;
  bit          m_wait = 0;
  int unsigned m_waited = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned w);
    int unsigned mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic in_t nop();
    in_t n;
    n = '{rs: 5'd0, rt: 5'd0, exrt: 5'd0, uses: 1'b0, mtr: 1'b0, rw: 1'b0,
          redir: 1'b0, acc: 1'b0, ack: 1'b0};
    return n;
  endfunction

  function automatic in_t rnd(input int unsigned ackp);
    in_t n;
    logic [4:0] pool [5];
    pool[0] = 5'd0; pool[1] = 5'd1; pool[2] = 5'd2; pool[3] = 5'd5; pool[4] = 5'd31;
    n.rs    = pool[$urandom_range(0, 4)];
    n.rt    = pool[$urandom_range(0, 4)];
    n.exrt  = pool[$urandom_range(0, 4)];
    n.uses  = 1'($urandom_range(0, 1));
    n.mtr   = 1'($urandom_range(0, 1));
    n.rw    = 1'($urandom_range(0, 3) != 0);
    n.redir = 1'($urandom_range(0, 5) == 0);
    n.acc   = 1'($urandom_range(0, 2) == 0);
    n.ack   = 1'($urandom_range(0, 9) < ackp);
    return n;
  endfunction

  task automatic put_inputs();
    id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.uses; ex_rt = s.exrt;
    ex_memtoreg = s.mtr; ex_regwr = s.rw; redirect = s.redir;
    mem_access = s.acc; mem_ack = s.ack;
  endtask

  // One normal cycle: drive staged inputs, predict, advance the model.
  task automatic apply();
    exp_t e;
    bit   lu, hold, flushed;
    @(negedge CLK);
    RESET = 1'b0;
    put_inputs();
    e.st    = m_err ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
    e.err   = m_err;
    e.stall = m_stall;
    e.flush = m_flush;
    lu   = s.mtr && s.rw && (s.exrt != 0) &&
           ((s.exrt == s.rs) || (s.uses && (s.exrt == s.rt)));
    hold = !m_err && s.acc && !s.ack;
    e.req = m_err ? 1'b0 : s.acc;
    e.idex_care = 1'b1;
    flushed = 0;
    if (m_err || hold) begin
      e.pc = 0; e.ifid = 0; e.idex = 0; e.exmem = 0;
      e.ifid_fl = 0; e.idex_fl = 0; e.bubble = 1;
    end else if (s.redir) begin
      e.pc = 1; e.ifid = 1; e.idex = 1; e.exmem = 1;
      e.ifid_fl = 1; e.idex_fl = 1; e.bubble = 0;
      flushed = 1;
    end else if (lu) begin
      e.pc = 0; e.ifid = 0; e.idex = 1; e.exmem = 1;
      e.ifid_fl = 0; e.idex_fl = 1; e.bubble = 0;
      e.idex_care = 1'b0;
    end else begin
      e.pc = 1; e.ifid = 1; e.idex = 1; e.exmem = 1;
      e.ifid_fl = 0; e.idex_fl = 0; e.bubble = 0;
    end
    q.push_back(e);
    if (!e.pc) m_stall++;
    if (flushed) m_flush++;
    if (!m_err) begin
      if (hold) begin
        if (m_wait) begin
          m_waited++;
          if (m_waited == TMO) begin
            m_err  = 1;
            m_wait = 0;
          end
        end else begin
          m_wait   = 1;
          m_waited = 0;
        end
      end else begin
        m_wait = 0;
      end
    end
  endtask

  // Reset cycles; with mid set, RESET rises between clock edges.
  task automatic reset_cycles(input int unsigned n, input bit mid);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge CLK);
      if (mid && i == 0) #1;
      RESET = 1'b1;
      s = rnd(5);
      put_inputs();
      e = '{pc: 0, ifid: 0, ifid_fl: 1, idex: 0, idex_fl: 1, exmem: 0,
            bubble: 1, req: 0, err: 0, idex_care: 1, st: 2'd0, stall: 0, flush: 0};
      q.push_back(e);
      m_err = 0; m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    end
  endtask

  task automatic repeat_apply(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) apply();
  endtask

  // Monitor: compare every cycle's outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc_en",        32'(pc_en),        32'(e.pc));
        chk("ifid_en",      32'(ifid_en),      32'(e.ifid));
        chk("ifid_flush",   32'(ifid_flush),   32'(e.ifid_fl));
        if (e.idex_care) chk("idex_en", 32'(idex_en), 32'(e.idex));
        chk("idex_flush",   32'(idex_flush),   32'(e.idex_fl));
        chk("exmem_en",     32'(exmem_en),     32'(e.exmem));
        chk("memwb_bubble", 32'(memwb_bubble), 32'(e.bubble));
        chk("mem_req",      32'(mem_req),      32'(e.req));
        chk("state",        32'(state),        32'(e.st));
        chk("err",          32'(err),          32'(e.err));
        chk("stall_cnt",    32'(stall_cnt),    sat(e.stall, W_BIG));
        chk("flush_cnt",    32'(flush_cnt),    sat(e.flush, W_BIG));
        chk("sat_state",    32'(s_state),      32'(e.st));
        chk("sat_pc_en",    32'(s_pc_en),      32'(e.pc));
        chk("sat_stall",    32'(s_stall_cnt),  sat(e.stall, W_SAT));
        chk("sat_flush",    32'(s_flush_cnt),  sat(e.flush, W_SAT));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ackp;
    reset_cycles(2, 0);

    // Load-use stall, then normal.
    s = nop(); s.mtr = 1; s.rw = 1; s.exrt = 5'd5; s.rs = 5'd5; apply();
    s = nop(); apply();
    // r0 destination never stalls; redirect overrides load-use.
    s = nop(); s.mtr = 1; s.rw = 1; s.exrt = 5'd0; s.rs = 5'd0; apply();
    s = nop(); s.mtr = 1; s.rw = 1; s.exrt = 5'd7; s.rt = 5'd7; s.uses = 1; apply();
    s = nop(); s.mtr = 1; s.rw = 1; s.exrt = 5'd5; s.rs = 5'd5; s.redir = 1; apply();
    s = nop(); apply();

    // Memory wait of three cycles then ack.
    reset_cycles(1, 1);
    s = nop(); s.acc = 1; repeat_apply(3);
    s.ack = 1; apply();
    s = nop(); apply();

    // Redirect held across a two-cycle hold, applied in the ack cycle.
    s = nop(); s.acc = 1; s.redir = 1; repeat_apply(2);
    s.ack = 1; apply();
    s = nop(); apply();

    // Timeout into ERROR, stays there, reset between edges.
    reset_cycles(1, 0);
    s = nop(); s.acc = 1; repeat_apply(12);
    s = nop(); s.redir = 1; s.ack = 1; repeat_apply(2);
    reset_cycles(1, 1);
    s = nop(); apply();

    // Ack on the last allowed wait cycle returns to RUN.
    s = nop(); s.acc = 1; repeat_apply(8);
    s.ack = 1; apply();
    s = nop(); apply();

    // Access withdrawn mid-wait is not an error; reset mid-wait.
    s = nop(); s.acc = 1; repeat_apply(4);
    s = nop(); apply();
    s = nop(); s.acc = 1; repeat_apply(3);
    reset_cycles(1, 1);
    s = nop(); apply();

    // Random traffic with varying ack likelihood and occasional resets.
    ackp = 5;
    for (int unsigned i = 0; i < 3000; i++) begin
      if (i % 64 == 0) ackp = $urandom_range(1, 7);
      if ($urandom_range(0, 199) == 0) begin
        reset_cycles($urandom_range(1, 2), 1'($urandom_range(0, 1)));
      end else begin
        s = rnd(ackp);
        apply();
      end
    end

    repeat (3) @(negedge CLK);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
